// File: rtl/vga_dither_out.sv
// vga_dither_out: RGB666 -> RGB222 output stage for the Tiny VGA PMOD.
// Two register stages: S1 captures the pixel and looks up its Bayer
// threshold; S2 quantises, blanks and drives the PMOD pins. Every signal
// (colour, blanking, syncs) sees exactly two clocks of latency.
//
// Stream protocol: one pixel per clock, no valid/ready. Every clock edge
// consumes the inputs and presents the pixel consumed two edges earlier.
module vga_dither_out #(
    parameter bit SYNC_IDLE = 1'b1,
    parameter bit TEMPORAL  = 1'b1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [5:0] r_in,
    input  logic [5:0] g_in,
    input  logic [5:0] b_in,
    input  logic [1:0] hpos_lsb,
    input  logic [1:0] vpos_lsb,
    input  logic       hsync_in,
    input  logic       vsync_in,
    input  logic       display_on,
    input  logic       dither_en,
    output logic [7:0] uo_out,
    output logic [1:0] frame_phase
);

    // 4x4 ordered-dither threshold matrix, indexed [y][x].
    function automatic logic [3:0] bayer(input logic [1:0] y, input logic [1:0] x);
        logic [3:0] t;
        t = 4'd0;
        case ({y, x})
            4'b00_00: t = 4'd0;
            4'b00_01: t = 4'd8;
            4'b00_10: t = 4'd2;
            4'b00_11: t = 4'd10;
            4'b01_00: t = 4'd12;
            4'b01_01: t = 4'd4;
            4'b01_10: t = 4'd14;
            4'b01_11: t = 4'd6;
            4'b10_00: t = 4'd3;
            4'b10_01: t = 4'd11;
            4'b10_10: t = 4'd1;
            4'b10_11: t = 4'd9;
            4'b11_00: t = 4'd15;
            4'b11_01: t = 4'd7;
            4'b11_10: t = 4'd13;
            4'b11_11: t = 4'd5;
            default:  t = 4'd0;
        endcase
        return t;
    endfunction

    // Round a 6-bit channel up to the next 2-bit level when its fraction
    // beats the threshold; level 3 never rounds further.
    function automatic logic [1:0] quant(input logic [5:0] v, input logic [3:0] t,
                                         input logic en);
        logic [1:0] q;
        q = v[5:4];
        if (en && (v[3:0] > t) && (q != 2'd3)) begin
            q = q + 2'd1;
        end
        return q;
    endfunction

    logic [1:0] r_phase;
    logic       r_vsync_prev;

    logic [5:0] r_r_s1;
    logic [5:0] r_g_s1;
    logic [5:0] r_b_s1;
    logic       r_hsync_s1;
    logic       r_vsync_s1;
    logic       r_de_s1;
    logic       r_den_s1;
    logic [3:0] r_t_s1;

    logic [7:0] r_out;

    logic [1:0] w_x;
    logic [1:0] w_y;
    logic       w_vs_edge;
    logic [1:0] w_rq;
    logic [1:0] w_gq;
    logic [1:0] w_bq;

    // Phase rotates the matrix by flipping x/y; the pixel sampled on the
    // edge cycle still sees the old phase because r_phase updates with it.
    assign w_x       = hpos_lsb ^ {2{r_phase[0]}};
    assign w_y       = vpos_lsb ^ {2{r_phase[1]}};
    assign w_vs_edge = (r_vsync_prev == SYNC_IDLE) && (vsync_in == ~SYNC_IDLE);

    // Frame phase counter, advanced on each vsync assertion edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_phase      <= 2'd0;
            r_vsync_prev <= SYNC_IDLE;
        end else begin
            r_vsync_prev <= vsync_in;
            if (TEMPORAL && w_vs_edge) begin
                r_phase <= r_phase + 2'd1;
            end
        end
    end

    // S1: capture pixel, controls and its dither threshold.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_r_s1     <= 6'd0;
            r_g_s1     <= 6'd0;
            r_b_s1     <= 6'd0;
            r_hsync_s1 <= SYNC_IDLE;
            r_vsync_s1 <= SYNC_IDLE;
            r_de_s1    <= 1'b0;
            r_den_s1   <= 1'b0;
            r_t_s1     <= 4'd0;
        end else begin
            r_r_s1     <= r_in;
            r_g_s1     <= g_in;
            r_b_s1     <= b_in;
            r_hsync_s1 <= hsync_in;
            r_vsync_s1 <= vsync_in;
            r_de_s1    <= display_on;
            r_den_s1   <= dither_en;
            r_t_s1     <= bayer(w_y, w_x);
        end
    end

    assign w_rq = r_de_s1 ? quant(r_r_s1, r_t_s1, r_den_s1) : 2'd0;
    assign w_gq = r_de_s1 ? quant(r_g_s1, r_t_s1, r_den_s1) : 2'd0;
    assign w_bq = r_de_s1 ? quant(r_b_s1, r_t_s1, r_den_s1) : 2'd0;

    // S2: register quantised, blanked colour and syncs onto the pin map.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out <= {SYNC_IDLE, 3'b000, SYNC_IDLE, 3'b000};
        end else begin
            r_out <= {r_hsync_s1, w_bq[0], w_gq[0], w_rq[0],
                      r_vsync_s1, w_bq[1], w_gq[1], w_rq[1]};
        end
    end

    assign uo_out      = r_out;
    assign frame_phase = r_phase;

endmodule

// File: tb/tb_vga_dither_out.sv
// Bench for vga_dither_out: hand-computed vector table streamed at one
// pixel per clock, directed temporal/reset sequences, then a random run
// checked against an independent model of the quantisation formula.
module tb_vga_dither_out;

    typedef struct {
        logic [5:0] r;
        logic [5:0] g;
        logic [5:0] b;
        logic [1:0] hp;
        logic [1:0] vp;
        logic       hs;
        logic       vs;
        logic       de;
        logic       den;
        logic [7:0] exp;
    } px_t;

    logic       clk;
    logic       rst_n;
    logic [5:0] r_in, g_in, b_in;
    logic [1:0] hpos_lsb, vpos_lsb;
    logic       hsync_in, vsync_in, display_on, dither_en;
    logic [7:0] uo_out;
    logic [1:0] frame_phase;

    int n_vec = 0;
    int n_err = 0;

    logic [7:0] exp_q[$];
    logic [1:0] m_phase;
    logic       m_prev;
    px_t        vecs[$];

    int bayer_m[4][4] = '{'{0, 8, 2, 10}, '{12, 4, 14, 6}, '{3, 11, 1, 9}, '{15, 7, 13, 5}};

    vga_dither_out dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .r_in        (r_in),
        .g_in        (g_in),
        .b_in        (b_in),
        .hpos_lsb    (hpos_lsb),
        .vpos_lsb    (vpos_lsb),
        .hsync_in    (hsync_in),
        .vsync_in    (vsync_in),
        .display_on  (display_on),
        .dither_en   (dither_en),
        .uo_out      (uo_out),
        .frame_phase (frame_phase)
    );

    // clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%02h, expected 0x%02h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic px_t mk(input logic [5:0] r, input logic [5:0] g, input logic [5:0] b,
                               input logic [1:0] hp, input logic [1:0] vp, input logic hs,
                               input logic vs, input logic de, input logic den,
                               input logic [7:0] exp);
        px_t p;
        p.r = r; p.g = g; p.b = b; p.hp = hp; p.vp = vp;
        p.hs = hs; p.vs = vs; p.de = de; p.den = den; p.exp = exp;
        return p;
    endfunction

    // Reference: threshold from the matrix, add one level when the fraction
    // beats it, clamp to 3.
    function automatic logic [1:0] model_ch(input logic [5:0] v, input int t, input logic den);
        int s;
        s = int'(v[5:4]);
        if (den && int'(v[3:0]) > t) s = s + 1;
        if (s > 3) s = 3;
        return s[1:0];
    endfunction

    function automatic logic [7:0] model_out(input px_t p, input logic [1:0] ph);
        int x, y, t;
        logic [1:0] rq, gq, bq;
        x = int'(p.hp ^ {ph[0], ph[0]});
        y = int'(p.vp ^ {ph[1], ph[1]});
        t = bayer_m[y][x];
        rq = p.de ? model_ch(p.r, t, p.den) : 2'd0;
        gq = p.de ? model_ch(p.g, t, p.den) : 2'd0;
        bq = p.de ? model_ch(p.b, t, p.den) : 2'd0;
        return {p.hs, bq[0], gq[0], rq[0], p.vs, bq[1], gq[1], rq[1]};
    endfunction

    // driver: present one pixel, queue its expected output, check the pins
    task automatic apply(input px_t p, input bit use_model);
        logic [7:0] e;
        r_in = p.r; g_in = p.g; b_in = p.b;
        hpos_lsb = p.hp; vpos_lsb = p.vp;
        hsync_in = p.hs; vsync_in = p.vs;
        display_on = p.de; dither_en = p.den;
        e = use_model ? model_out(p, m_phase) : p.exp;
        if (m_prev == 1'b1 && p.vs == 1'b0) m_phase = m_phase + 2'd1;
        m_prev = p.vs;
        exp_q.push_back(e);
        tick();
        if (exp_q.size() == 2) check("uo_out", uo_out, exp_q.pop_front());
        else check("uo_out_hold", uo_out, 8'h88);
        check("frame_phase", {6'd0, frame_phase}, {6'd0, m_phase});
    endtask

    function automatic px_t idle();
        return mk(6'd0, 6'd0, 6'd0, 2'd0, 2'd0, 1'b1, 1'b1, 1'b0, 1'b0, 8'h88);
    endfunction

    function automatic px_t rand_px(input bit allow_vs);
        px_t p;
        p = mk(6'($urandom_range(0, 63)), 6'($urandom_range(0, 63)), 6'($urandom_range(0, 63)),
               2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
               1'($urandom_range(0, 7) != 0),
               allow_vs ? 1'($urandom_range(0, 40) != 0) : 1'b1,
               1'($urandom_range(0, 5) != 0), 1'($urandom_range(0, 3) != 0), 8'h00);
        return p;
    endfunction

    initial begin
        m_phase = 2'd0;
        m_prev  = 1'b1;

        // hand-computed vectors, phase 0, syncs idle unless noted
        vecs.push_back(mk(6'h2F, 6'h10, 6'h3F, 2'd0, 2'd0, 1, 1, 1, 0, 8'hED)); // truncation
        vecs.push_back(mk(6'h18, 6'h18, 6'h18, 2'd0, 2'd0, 1, 1, 1, 1, 8'h8F)); // (0,0) -> 2
        vecs.push_back(mk(6'h18, 6'h18, 6'h18, 2'd1, 2'd0, 1, 1, 1, 1, 8'hF8)); // (1,0) -> 1
        vecs.push_back(mk(6'h0F, 6'h0F, 6'h0F, 2'd0, 2'd3, 1, 1, 1, 1, 8'h88)); // (0,3) -> 0
        vecs.push_back(mk(6'h0F, 6'h0F, 6'h0F, 2'd1, 2'd3, 1, 1, 1, 1, 8'hF8)); // (1,3) -> 1
        vecs.push_back(mk(6'h3F, 6'h3F, 6'h3F, 2'd0, 2'd0, 1, 1, 1, 1, 8'hFF)); // saturate
        vecs.push_back(mk(6'h3F, 6'h3F, 6'h3F, 2'd3, 2'd1, 1, 1, 1, 1, 8'hFF));
        vecs.push_back(mk(6'h3F, 6'h3F, 6'h3F, 2'd2, 2'd2, 1, 1, 1, 1, 8'hFF));
        vecs.push_back(mk(6'h3F, 6'h3F, 6'h3F, 2'd1, 2'd3, 1, 1, 1, 1, 8'hFF));
        vecs.push_back(mk(6'h11, 6'h11, 6'h11, 2'd2, 2'd2, 1, 1, 1, 1, 8'hF8)); // t=1, f=1
        vecs.push_back(mk(6'h12, 6'h12, 6'h12, 2'd2, 2'd2, 1, 1, 1, 1, 8'h8F)); // t=1, f=2
        vecs.push_back(mk(6'h18, 6'h18, 6'h18, 2'd0, 2'd0, 0, 1, 1, 1, 8'h0F)); // hsync pulse
        vecs.push_back(mk(6'h18, 6'h18, 6'h18, 2'd0, 2'd0, 0, 1, 0, 1, 8'h08)); // blanked
        vecs.push_back(mk(6'h18, 6'h18, 6'h18, 2'd0, 2'd0, 0, 1, 1, 1, 8'h0F));
        vecs.push_back(mk(6'h18, 6'h18, 6'h18, 2'd0, 2'd0, 1, 1, 1, 0, 8'hF8)); // dither off
        vecs.push_back(mk(6'h18, 6'h18, 6'h18, 2'd0, 2'd0, 1, 1, 1, 1, 8'h8F)); // dither on
        vecs.push_back(mk(6'h3F, 6'h00, 6'h20, 2'd3, 2'd3, 1, 1, 1, 0, 8'h9D));

        // reset held with random inputs
        rst_n = 1'b0;
        for (int i = 0; i < 5; i++) begin
            r_in = 6'($urandom_range(0, 63)); g_in = 6'($urandom_range(0, 63));
            b_in = 6'($urandom_range(0, 63));
            hpos_lsb = 2'($urandom_range(0, 3)); vpos_lsb = 2'($urandom_range(0, 3));
            hsync_in = 1'($urandom_range(0, 1)); vsync_in = 1'($urandom_range(0, 1));
            display_on = 1'($urandom_range(0, 1)); dither_en = 1'($urandom_range(0, 1));
            tick();
            check("reset_uo_out", uo_out, 8'h88);
            check("reset_phase", {6'd0, frame_phase}, 8'd0);
        end
        rst_n = 1'b1;

        // vector table
        foreach (vecs[i]) apply(vecs[i], 1'b0);
        apply(idle(), 1'b0);
        apply(idle(), 1'b0);

        // temporal: four vsync pulses, phase-3 pixels checked by hand
        for (int k = 0; k < 4; k++) begin
            px_t p;
            p = idle();
            p.vs = 1'b0;
            apply(p, 1'b1);
            check("phase_step", {6'd0, frame_phase}, 8'((k + 1) % 4));
            apply(idle(), 1'b1);
            apply(idle(), 1'b1);
            if (k == 2) begin
                apply(mk(6'h16, 6'h16, 6'h16, 2'd0, 2'd0, 1, 1, 1, 1, 8'h8F), 1'b0);
                apply(mk(6'h15, 6'h15, 6'h15, 2'd0, 2'd0, 1, 1, 1, 1, 8'hF8), 1'b0);
                apply(idle(), 1'b1);
                apply(idle(), 1'b1);
            end
        end

        // random stream with occasional vsync edges
        for (int i = 0; i < 1500; i++) apply(rand_px(1'b1), 1'b1);

        // asynchronous reset mid-line
        #2 rst_n = 1'b0;
        #1;
        check("midline_reset_uo_out", uo_out, 8'h88);
        check("midline_reset_phase", {6'd0, frame_phase}, 8'd0);
        tick();
        check("midline_reset_hold", uo_out, 8'h88);
        rst_n = 1'b1;
        exp_q.delete();
        m_phase = 2'd0;
        m_prev  = 1'b1;

        // random stream after recovery
        for (int i = 0; i < 1500; i++) apply(rand_px(1'b1), 1'b1);
        apply(idle(), 1'b1);
        apply(idle(), 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
